// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Read-side output adapter of the dual-clock FIFO (read clock domain).
//   Turns the FIFO pop interface (pop request, registered empty flag, data one
//   cycle after the pop) into a valid/ready stream. A 3-entry in-order buffer
//   absorbs the read latency so the stream can move one word per clock.
//   Burst boundaries are marked with last_o.
//
// Ports
//   rd_clk_i    in   read-domain clock, rising edge
//   srst_i      in   synchronous active-high reset
//   rd_empty_i  in   FIFO empty flag (registered in the FIFO read logic)
//   rd_data_i   in   FIFO read data, valid the cycle after an issued pop
//   rd_req_o    out  pop request, only while rd_empty_i=0 and not in reset
//   data_o      out  head word of the output buffer
//   valid_o     out  data_o holds a word
//   ready_i     in   downstream accepts the head word this cycle
//   last_o      out  head word is the last word of a burst (qualified by valid_o)
//
// Handshake: a word transfers on a rising edge where valid_o=1 and ready_i=1.
// Once valid_o is high, data_o and last_o hold until that transfer happens;
// valid_o never drops without a transfer.
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
  parameter int DWIDTH    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              rd_clk_i,
  input  logic              srst_i,
  input  logic              rd_empty_i,
  input  logic [DWIDTH-1:0] rd_data_i,
  output logic              rd_req_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);

  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] LAST_POS = BW'(BURST_LEN - 1);

  logic [1:0]        r_cnt;       // occupied buffer entries, 0..3
  logic              r_inflight;  // pop issued last cycle, data arrives now
  logic [BW-1:0]     r_burst;     // position of the head word in its burst
  logic [DWIDTH-1:0] r_buf [3];   // entry 0 is the head

  logic [2:0]        w_credit;
  logic              w_valid;
  logic              w_acc;
  logic              w_cap;
  logic [1:0]        w_wr_idx;
  logic [1:0]        w_cnt_nxt;
  logic [DWIDTH-1:0] w_buf_nxt [3];

  // Credit counts words already buffered plus the one still on its way, so a
  // pop is only issued when its data is guaranteed a free slot next cycle.
  // Built from registered state only: ready_i never reaches rd_req_o.
  assign w_credit = {1'b0, r_cnt} + {2'b00, r_inflight};
  assign rd_req_o = ~rd_empty_i & ~srst_i & (w_credit < 3'd3);

  assign w_valid   = (r_cnt != 2'd0);
  assign w_acc     = w_valid & ready_i;
  assign w_cap     = r_inflight;
  // The head shifts out before the capture lands, so the tail slot moves
  // down by one on an accept.
  assign w_wr_idx  = r_cnt - {1'b0, w_acc};
  assign w_cnt_nxt = r_cnt + {1'b0, w_cap} - {1'b0, w_acc};

  always_comb begin
    w_buf_nxt = r_buf;
    if (w_acc) begin
      w_buf_nxt[0] = r_buf[1];
      w_buf_nxt[1] = r_buf[2];
    end
    if (w_cap) begin
      case (w_wr_idx)
        2'd0:    w_buf_nxt[0] = rd_data_i;
        2'd1:    w_buf_nxt[1] = rd_data_i;
        2'd2:    w_buf_nxt[2] = rd_data_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge rd_clk_i) begin
    if (srst_i) begin
      // Data of a pop issued just before reset is dropped by clearing
      // r_inflight; the FIFO itself is reset alongside this block.
      r_cnt      <= 2'd0;
      r_inflight <= 1'b0;
      r_burst    <= '0;
      r_buf[0]   <= '0;
      r_buf[1]   <= '0;
      r_buf[2]   <= '0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_inflight <= rd_req_o;
      r_buf      <= w_buf_nxt;
      if (w_acc) begin
        r_burst <= (r_burst == LAST_POS) ? '0 : r_burst + BW'(1);
      end
    end
  end

  assign data_o  = r_buf[0];
  assign valid_o = w_valid;
  assign last_o  = w_valid & (r_burst == LAST_POS);

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int BL = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          srst_i;
  logic          rd_empty_i;
  logic [DW-1:0] rd_data_i;
  logic          rd_req_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;

  always #5 clk = ~clk;

  fifo_rd_stream #(.DWIDTH(DW), .BURST_LEN(BL)) dut (
    .rd_clk_i   (clk),
    .srst_i     (srst_i),
    .rd_empty_i (rd_empty_i),
    .rd_data_i  (rd_data_i),
    .rd_req_o   (rd_req_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o)
  );

  // ---------------- reference model / scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] fifo_q[$];   // words still inside the upstream FIFO
  logic [DW-1:0] exp_q[$];    // every word not yet delivered, in stream order
  logic [DW-1:0] out_q[$];    // words the adapter holds (buffer contents)
  bit            pend = 0;    // a popped word is on its way this cycle
  logic [DW-1:0] pend_word = '0;
  int            acc_cnt = 0; // accepts since reset
  int            pops = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(DW'(base + i));
      exp_q.push_back(DW'(base + i));
    end
  endtask

  task automatic load_rand(input int n);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs against the model,
  // then advance the model across the rising edge.
  task automatic step(input logic rdy, input logic rst, input logic force_empty);
    logic e_valid, e_req, e_last, acc;
    int   lost;
    @(negedge clk);
    ready_i    = rdy;
    srst_i     = rst;
    rd_empty_i = force_empty || (fifo_q.size() == 0);
    #1;
    e_valid = (out_q.size() != 0);
    e_req   = !rd_empty_i && !rst && ((out_q.size() + int'(pend)) < 3);
    e_last  = e_valid && ((acc_cnt % BL) == BL - 1);
    check("rd_req_o", 32'(rd_req_o), 32'(e_req));
    check("valid_o", 32'(valid_o), 32'(e_valid));
    check("last_o", 32'(last_o), 32'(e_last));
    if (e_valid) check("data_o", 32'(data_o), 32'(out_q[0]));
    acc = e_valid && rdy && !rst;
    if (acc) begin
      if (exp_q.size() != 0) check("sb_order", 32'(data_o), 32'(exp_q.pop_front()));
      else check("sb_underflow", 32'(exp_q.size()), 32'd1);
    end
    @(posedge clk);
    if (rst) begin
      lost = out_q.size() + int'(pend);
      for (int i = 0; i < lost; i++) void'(exp_q.pop_front());
      out_q.delete();
      pend    = 0;
      acc_cnt = 0;
    end else begin
      if (acc) begin
        void'(out_q.pop_front());
        acc_cnt++;
      end
      if (pend) out_q.push_back(pend_word);
      pend = e_req;
      if (e_req) begin
        pend_word = fifo_q.pop_front();
        pops++;
      end
    end
    check("buf_overflow", 32'(out_q.size() <= 3), 32'd1);
    #1;
    rd_data_i = pend ? pend_word : DW'($urandom);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    srst_i     = 1'b1;
    ready_i    = 1'b0;
    rd_empty_i = 1'b1;
    rd_data_i  = '0;
    @(posedge clk);

    // Reset held 3 cycles with a non-empty FIFO, then stream with ready=1.
    load(8, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    check("reset_data_o", 32'(data_o), 32'd0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0);
    check("t1_delivered", 32'(acc_cnt), 32'd8);

    // Backpressure: 10 cycles of ready=0 issue exactly 3 pops.
    step(1'b0, 1'b1, 1'b0);
    load(8, 1);
    pops = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    check("bp_pops", 32'(pops), 32'd3);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0);
    check("bp_delivered", 32'(acc_cnt), 32'd8);

    // ready toggling with 5 words.
    step(1'b0, 1'b1, 1'b0);
    load(5, 8'h11);
    for (int i = 0; i < 18; i++) step(logic'(i % 2 == 0), 1'b0, 1'b0);
    check("toggle_delivered", 32'(acc_cnt), 32'd5);
    check("toggle_left", 32'(exp_q.size()), 32'd0);

    // Single word, then empty.
    step(1'b0, 1'b1, 1'b0);
    load(1, 8'hA5);
    pops = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    check("single_pops", 32'(pops), 32'd1);
    check("single_left", 32'(exp_q.size()), 32'd0);

    // Reset with two buffered words and one in flight.
    step(1'b0, 1'b1, 1'b0);
    load(8, 8'h40);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
    check("rst_mid_left", 32'(exp_q.size()), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 16) load_rand($urandom_range(1, 3));
      step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 99) == 0),
           logic'($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
    check("rand_left", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side output adapter of the dual-clock FIFO. It sits directly downstream of the read pointer/empty logic and the FIFO memory in the read clock domain. It converts the FIFO's pop interface (request, registered empty flag, one-cycle read latency) into a valid/ready stream with a 3-entry output buffer. The stream sustains one word per clock and marks burst boundaries with `last_o`.

## Interface
- `DWIDTH`, 8: data word width.
- `BURST_LEN`, 4: words per burst; `last_o` marks every BURST_LEN-th word; legal range 1..256.
- `rd_clk_i` input 1: read-domain clock; all logic is on its rising edge.
- `srst_i` input 1: reset, synchronous and active-high.
- `rd_empty_i` input 1: FIFO empty flag, registered in the FIFO's read logic.
- `rd_data_i` input DWIDTH: FIFO memory read data, valid exactly one cycle after an accepted pop.
- `rd_req_o` output 1: pop request to the FIFO; asserted only while `rd_empty_i`=0.
- `data_o` output DWIDTH: head word of the output buffer.
- `valid_o` output 1: `data_o` holds a word.
- `ready_i` input 1: downstream accepts the word this cycle.
- `last_o` output 1: the head word is the final word of a burst; qualified by `valid_o`.

## Operation
- A word transfers on a clock edge where `valid_o`=1 and `ready_i`=1 (accept).
- Internal state:
  - `buf_cnt` (0..3): number of occupied buffer entries.
  - `inflight` (0/1): a pop was issued last cycle and its data arrives this cycle.
  - `burst_cnt` (0..BURST_LEN-1): position of the head word within its burst.
- Issue rule:
  - `rd_req_o = ~rd_empty_i & ~srst_i & (buf_cnt + inflight < 3)`.
  - The rule uses registered state only; there is no combinational path from `ready_i` to `rd_req_o`.
- Capture:
  - If `inflight`=1, `rd_data_i` is written into the buffer tail at the end of the cycle.
  - The credit rule guarantees a free slot, so data is never dropped. Overflow is a design error; the bench asserts against it.
- The buffer is an in-order FIFO of 3 registers. A write and an accept in the same cycle leave `buf_cnt` unchanged.
- `valid_o = (buf_cnt != 0)`. `data_o` is the head entry.
- Output holding rules:
  - `data_o` is held stable while `valid_o`=1 and `ready_i`=0.
  - `valid_o` never drops without an accept.
- Burst counting:
  - `last_o = valid_o & (burst_cnt == BURST_LEN-1)`.
  - On accept, `burst_cnt` increments and wraps to 0 after BURST_LEN-1.
  - `burst_cnt` does not advance without an accept.
  - With BURST_LEN=1, `last_o` equals `valid_o`.
- Reset:
  - Clears `buf_cnt`, `inflight` and `burst_cnt`.
  - Read data for a pop issued in the cycle before reset is discarded.
  - The FIFO's own pointers are reset separately by its asynchronous clear. The FIFO is reset whenever this block is reset, so the discarded word is not lost from an ongoing stream.

## Timing
- Reset values: `rd_req_o`=0, `valid_o`=0, `last_o`=0, `data_o`=0.
- `rd_req_o` is held at 0 during every cycle in which `srst_i`=1.
- Empty-to-valid latency, from a cycle T where `rd_empty_i`=0 with an empty buffer:
  - `rd_req_o`=1 in cycle T.
  - `rd_data_i` is valid in T+1 and captured at the end of T+1.
  - `valid_o`=1 from T+2.
- Throughput: with `ready_i` held at 1 and the FIFO non-empty, one accept per cycle after the initial 2-cycle fill.
- Backpressure:
  - With `ready_i`=0, at most 3 further pops are issued.
  - `rd_req_o` then stays 0 until an accept frees a slot.
  - `rd_req_o` reasserts in the cycle after that accept.
- FIFO drains to empty (`rd_empty_i`=1): `rd_req_o` goes to 0 in the same cycle. Buffered words are still delivered in order.
- Simultaneous accept, capture and issue in one cycle are all legal. `buf_cnt` changes by (capture − accept) in that cycle.

## Test plan
- Reset held 3 cycles with `rd_empty_i`=0: `rd_req_o`=0 throughout. After release, `rd_req_o`=1 in the first cycle and `valid_o`=1 two cycles later.
- FIFO preloaded with 0x01..0x08, `ready_i`=1, BURST_LEN=4:
  - `data_o` sequence is 0x01..0x08 on 8 consecutive accept cycles.
  - `last_o`=1 exactly on 0x04 and 0x08.
- Same preload with `ready_i`=0 for 10 cycles:
  - Exactly 3 pops occur; `data_o`=0x01 stays stable.
  - Releasing `ready_i` then yields 0x01..0x08 with no gap after the first accept.
- `ready_i` toggling 1,0,1,0 with the FIFO holding 5 words: all 5 words are delivered in order with no duplication or loss, and `burst_cnt` advances only on accepts.
- FIFO with 1 word, then `rd_empty_i`=1:
  - One pop occurs and `valid_o` holds until accepted, then drops to 0.
  - `rd_req_o` stays 0 while empty.
- `srst_i` pulsed while `buf_cnt`=2 and `inflight`=1: next cycle `valid_o`=0 and the in-flight word is not presented. Recovery then follows the empty-to-valid latency.
